// File: rtl/except_ctrl.sv
// Exception resolution and flush sequencer between the memory stage and cp0_reg.
// Picks one exception by fixed priority, reports it to CP0, then flushes and settles.
module except_ctrl #(
    parameter logic [31:0] EXC_VEC_BEV1 = 32'hBFC0_0380,
    parameter logic [31:0] EXC_VEC_BEV0 = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic [8:0]  mem_exc_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    output logic [31:0] except_type_o,
    output logic [31:0] except_pc_o,
    output logic        except_delayslot_o,
    output logic [31:0] except_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        stall_o
);

    localparam logic [31:0] STATUS_FWD_MASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_FWD_MASK  = 32'h0000_0300;

    typedef enum logic [1:0] {IDLE, FLUSH, SETTLE} state_e;

    state_e      state_q;
    logic        int_pend_q, int_pend_d;
    logic [31:0] tgt_q, tgt_d;
    logic        flush_q, stall_q;
    logic [31:0] new_pc_q;

    logic [31:0] status_eff, cause_eff, epc_eff;
    logic [31:0] code;
    logic [31:0] target;
    logic        report;
    logic        unused_bits;

    // CP0 values as they will be after the write presented this cycle
    always_comb begin
        status_eff = cp0_status_i;
        cause_eff  = cp0_cause_i;
        epc_eff    = cp0_epc_i;
        if (cp0_we_i) begin
            case (cp0_waddr_i)
                5'd12:   status_eff = (cp0_status_i & ~STATUS_FWD_MASK) | (cp0_wdata_i & STATUS_FWD_MASK);
                5'd13:   cause_eff  = (cp0_cause_i & ~CAUSE_FWD_MASK) | (cp0_wdata_i & CAUSE_FWD_MASK);
                5'd14:   epc_eff    = cp0_wdata_i;
                default: ;
            endcase
        end
    end

    assign int_pend_d = (|(cause_eff[15:8] & status_eff[15:8])) && status_eff[0] && !status_eff[1];

    always_comb begin
        code = 32'h0;
        if (int_pend_q)        code = 32'h1;
        else if (mem_exc_i[0]) code = 32'hF;
        else if (mem_exc_i[1]) code = 32'hA;
        else if (mem_exc_i[2]) code = 32'h8;
        else if (mem_exc_i[3]) code = 32'h9;
        else if (mem_exc_i[4]) code = 32'hD;
        else if (mem_exc_i[5]) code = 32'hC;
        else if (mem_exc_i[7]) code = 32'h4;
        else if (mem_exc_i[8]) code = 32'h5;
        else if (mem_exc_i[6]) code = 32'hE;
    end

    assign target = (code == 32'hE) ? epc_eff : (status_eff[22] ? EXC_VEC_BEV1 : EXC_VEC_BEV0);
    assign report = !rst && (state_q == IDLE) && mem_valid_i && (code != 32'h0);
    assign tgt_d  = report ? target : tgt_q;

    assign except_type_o      = report ? code : 32'h0;
    assign except_pc_o        = rst ? 32'h0 : mem_pc_i;
    assign except_delayslot_o = !rst && mem_in_delayslot_i;
    assign except_addr_o      = rst ? 32'h0 : ((code == 32'hF) ? mem_pc_i : mem_addr_i);
    assign flush_o            = flush_q;
    assign new_pc_o           = new_pc_q;
    assign stall_o            = stall_q;

    assign unused_bits = ^{status_eff[31:23], status_eff[21:16], status_eff[7:2],
                           cause_eff[31:16], cause_eff[7:0]};

    // Report in IDLE, redirect for one cycle, then hold one cycle for CP0 to settle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            int_pend_q <= 1'b0;
            tgt_q      <= 32'h0;
            flush_q    <= 1'b0;
            stall_q    <= 1'b0;
            new_pc_q   <= 32'h0;
        end else begin
            int_pend_q <= int_pend_d;
            tgt_q      <= tgt_d;
            case (state_q)
                IDLE: begin
                    if (report) begin
                        state_q  <= FLUSH;
                        flush_q  <= 1'b1;
                        new_pc_q <= target;
                    end
                end
                FLUSH: begin
                    state_q  <= SETTLE;
                    flush_q  <= 1'b0;
                    new_pc_q <= 32'h0;
                    stall_q  <= 1'b1;
                end
                SETTLE: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    flush_q  <= 1'b0;
                    stall_q  <= 1'b0;
                    new_pc_q <= 32'h0;
                end
            endcase
        end
    end

endmodule
